// File: rtl/interrupt_unit_pkg.sv
// Shared definitions for the interrupt unit and the decoder that consumes it.
//   - system register indices addressed by RSR/WSR
//   - bit positions inside PCS
//   - FSM state encoding for the acknowledge sequencer
//   - pcSel value the decoder uses to take the interrupt redirect
package interrupt_unit_pkg;

  localparam logic [3:0] SR_PCS = 4'd0;
  localparam logic [3:0] SR_IHA = 4'd1;
  localparam logic [3:0] SR_IRA = 4'd2;
  localparam logic [3:0] SR_IDN = 4'd3;

  localparam int PCS_IE  = 0;
  localparam int PCS_OIE = 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_ACK  = 1'b1;

  localparam logic [1:0] PCSEL_INTA = 2'b11;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the pending interrupt vector.
//   req_i   : pending request bits, bit 0 highest priority
//   valid_o : at least one request is set
//   idx_o   : index of the lowest set bit (0 when none)
module irq_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [3:0]         idx_o
);

  // Scanning high to low lets the lowest set bit overwrite the result last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt sequencing and system registers beside the decode stage.
//   clk, reset_n      : system clock, asynchronous active-low reset
//   irq               : level-high requests, latched into a pending vector
//   stall             : pipeline hold, blocks taking an interrupt
//   pcIn              : PC in decode, saved as the return address
//   isReti/isRSR/isWSR: decoded system-instruction flags
//   sysRegAddr        : system register index (PCS/IHA/IRA/IDN)
//   wrtData           : WSR write data
//   sysDataOut        : RSR read data (0 when not reading)
//   intaSig           : one-cycle acknowledge strobe to the decoder
//   intaAddr          : redirect target (handler, or return address on RETI)
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | waiting for an enabled pending request
// ST_ACK  | acknowledge cycle, decoder redirects to IHA
module interrupt_unit
  import interrupt_unit_pkg::*;
#(
  parameter int                        DATA_BIT_WIDTH = 32,
  parameter int                        NUM_IRQ        = 4,
  parameter logic [DATA_BIT_WIDTH-1:0] IHA_RESET      = 'h0000_0100
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_IRQ-1:0]        irq,
  input  logic                      stall,
  input  logic [DATA_BIT_WIDTH-1:0] pcIn,
  input  logic                      isReti,
  input  logic                      isRSR,
  input  logic                      isWSR,
  input  logic [3:0]                sysRegAddr,
  input  logic [DATA_BIT_WIDTH-1:0] wrtData,
  output logic [DATA_BIT_WIDTH-1:0] sysDataOut,
  output logic                      intaSig,
  output logic [DATA_BIT_WIDTH-1:0] intaAddr
);

  logic                      state_q, state_d;
  logic [NUM_IRQ-1:0]        pend_q, pend_d;
  logic                      ie_q, ie_d;
  logic                      oie_q, oie_d;
  logic [DATA_BIT_WIDTH-1:0] iha_q, iha_d;
  logic [DATA_BIT_WIDTH-1:0] ira_q, ira_d;
  logic [3:0]                idn_q, idn_d;

  logic                      sel_valid;
  logic [3:0]                sel_idx;
  logic                      take;
  logic [NUM_IRQ-1:0]        clr_mask;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req_i   (pend_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  assign intaSig = (state_q == ST_ACK);

  // RETI/WSR in decode defer the take so a freshly written IE is only seen
  // the following cycle.
  assign take = (state_q == ST_IDLE) & sel_valid & ie_q & ~stall
              & ~isReti & ~isWSR;

  assign clr_mask = take ? (NUM_IRQ'(1) << sel_idx) : '0;

  always_comb begin
    state_d = state_q;
    // Clear is applied after the set, so the acknowledged line stays cleared
    // even if its request is still high in the entry cycle.
    pend_d  = (pend_q | irq) & ~clr_mask;
    ie_d    = ie_q;
    oie_d   = oie_q;
    iha_d   = iha_q;
    ira_d   = ira_q;
    idn_d   = idn_q;

    if (take) begin
      state_d = ST_ACK;
      ira_d   = pcIn;
      idn_d   = sel_idx;
      oie_d   = ie_q;
      ie_d    = 1'b0;
    end else if (state_q == ST_ACK) begin
      state_d = ST_IDLE;
    end

    if (!intaSig && isReti) begin
      ie_d = oie_q;
    end

    if (!intaSig && isWSR) begin
      case (sysRegAddr)
        SR_PCS: begin
          ie_d  = wrtData[PCS_IE];
          oie_d = wrtData[PCS_OIE];
        end
        SR_IHA:  iha_d = wrtData;
        SR_IRA:  ira_d = wrtData;
        SR_IDN:  idn_d = wrtData[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ie_q    <= 1'b0;
      oie_q   <= 1'b0;
      iha_q   <= IHA_RESET;
      ira_q   <= '0;
      idn_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ie_q    <= ie_d;
      oie_q   <= oie_d;
      iha_q   <= iha_d;
      ira_q   <= ira_d;
      idn_q   <= idn_d;
    end
  end

  always_comb begin
    sysDataOut = '0;
    if (isRSR) begin
      case (sysRegAddr)
        SR_PCS:  sysDataOut = {{(DATA_BIT_WIDTH-2){1'b0}}, oie_q, ie_q};
        SR_IHA:  sysDataOut = iha_q;
        SR_IRA:  sysDataOut = ira_q;
        SR_IDN:  sysDataOut = {{(DATA_BIT_WIDTH-4){1'b0}}, idn_q};
        default: sysDataOut = '0;
      endcase
    end
  end

  always_comb begin
    intaAddr = iha_q;
    if (!intaSig && isReti) begin
      intaAddr = ira_q;
    end
  end

endmodule

// File: tb/tb_interrupt_unit.sv
module tb_interrupt_unit;

  localparam int NIRQ = 4;

  logic        clk;
  logic        reset_n;
  logic [3:0]  irq;
  logic        stall;
  logic [31:0] pc_in;
  logic        is_reti, is_rsr, is_wsr;
  logic [3:0]  sr_addr;
  logic [31:0] wdata;
  logic [31:0] sdo;
  logic        inta;
  logic [31:0] inta_addr;

  int total = 0;
  int bad   = 0;

  interrupt_unit #(
    .DATA_BIT_WIDTH (32),
    .NUM_IRQ        (NIRQ),
    .IHA_RESET      (32'h0000_0100)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq        (irq),
    .stall      (stall),
    .pcIn       (pc_in),
    .isReti     (is_reti),
    .isRSR      (is_rsr),
    .isWSR      (is_wsr),
    .sysRegAddr (sr_addr),
    .wrtData    (wdata),
    .sysDataOut (sdo),
    .intaSig    (inta),
    .intaAddr   (inta_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic        stall;
    logic [31:0] pc;
    logic        reti, rsr, wsr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic        e_inta;
    logic [31:0] e_addr;
    logic [31:0] e_sdo;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic [3:0] i_irq, logic i_stall, logic [31:0] i_pc,
                              logic i_reti, logic i_rsr, logic i_wsr, logic [3:0] i_addr,
                              logic [31:0] i_wd, logic e_inta, logic [31:0] e_addr,
                              logic [31:0] e_sdo);
    vec_t v;
    v.irq = i_irq; v.stall = i_stall; v.pc = i_pc;
    v.reti = i_reti; v.rsr = i_rsr; v.wsr = i_wsr;
    v.addr = i_addr; v.wd = i_wd;
    v.e_inta = e_inta; v.e_addr = e_addr; v.e_sdo = e_sdo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] i_irq, input logic i_stall, input logic [31:0] i_pc,
                       input logic i_reti, input logic i_rsr, input logic i_wsr,
                       input logic [3:0] i_addr, input logic [31:0] i_wd);
    irq = i_irq; stall = i_stall; pc_in = i_pc;
    is_reti = i_reti; is_rsr = i_rsr; is_wsr = i_wsr;
    sr_addr = i_addr; wdata = i_wd;
  endtask

  task automatic idle();
    drive(4'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: architectural state as the programmer sees it.
  bit          m_pend[NIRQ];
  bit          m_ie, m_oie, m_ack;
  logic [31:0] m_iha, m_ira;
  logic [3:0]  m_idn;

  task automatic m_reset();
    for (int i = 0; i < NIRQ; i++) m_pend[i] = 1'b0;
    m_ie = 0; m_oie = 0; m_ack = 0;
    m_iha = 32'h100; m_ira = 0; m_idn = 0;
  endtask

  function automatic logic [31:0] m_read(logic [3:0] a);
    case (a)
      4'd0:    return {30'b0, m_oie, m_ie};
      4'd1:    return m_iha;
      4'd2:    return m_ira;
      4'd3:    return {28'b0, m_idn};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_edge();
    int  sel;
    bit  tk;
    sel = -1;
    for (int i = 0; i < NIRQ; i++) if (m_pend[i] && sel < 0) sel = i;
    tk = !m_ack && sel >= 0 && m_ie && !stall && !is_reti && !is_wsr;
    for (int i = 0; i < NIRQ; i++) if (irq[i]) m_pend[i] = 1'b1;
    if (tk) begin
      m_pend[sel] = 1'b0;
      m_ira = pc_in;
      m_idn = 4'(sel);
      m_oie = m_ie;
      m_ie  = 1'b0;
    end
    if (!m_ack && is_reti) m_ie = m_oie;
    if (!m_ack && is_wsr) begin
      case (sr_addr)
        4'd0: begin m_ie = wdata[0]; m_oie = wdata[1]; end
        4'd1: m_iha = wdata;
        4'd2: m_ira = wdata;
        4'd3: m_idn = wdata[3:0];
        default: ;
      endcase
    end
    m_ack = tk;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int at;
    int sel;

    //             irq  st  pc     reti rsr wsr addr wd     inta addr     sdo
    tbl[0]  = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h0);
    tbl[1]  = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd1, 32'h0, 0, 32'h100, 32'h100);
    tbl[2]  = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd2, 32'h0, 0, 32'h100, 32'h0);
    tbl[3]  = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd3, 32'h0, 0, 32'h100, 32'h0);
    tbl[4]  = mk(4'h0, 0, 32'h00, 0, 0, 0, 4'd0, 32'h0, 0, 32'h100, 32'h0);
    tbl[5]  = mk(4'h0, 0, 32'h00, 0, 0, 1, 4'd0, 32'h1, 0, 32'h100, 32'h0);
    tbl[6]  = mk(4'h4, 0, 32'h40, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h1);
    tbl[7]  = mk(4'h0, 0, 32'h40, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h1);
    tbl[8]  = mk(4'h0, 0, 32'h44, 0, 1, 0, 4'd0, 32'h0, 1, 32'h100, 32'h2);
    tbl[9]  = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd2, 32'h0, 0, 32'h100, 32'h40);
    tbl[10] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd3, 32'h0, 0, 32'h100, 32'h2);
    tbl[11] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h2);
    tbl[12] = mk(4'h0, 0, 32'h00, 1, 0, 0, 4'd0, 32'h0, 0, 32'h40,  32'h0);
    tbl[13] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h3);
    tbl[14] = mk(4'hA, 0, 32'h00, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h3);
    tbl[15] = mk(4'h0, 0, 32'h80, 0, 0, 0, 4'd0, 32'h0, 0, 32'h100, 32'h0);
    tbl[16] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd3, 32'h0, 1, 32'h100, 32'h1);
    tbl[17] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h2);
    tbl[18] = mk(4'h0, 0, 32'h00, 1, 0, 0, 4'd0, 32'h0, 0, 32'h80,  32'h0);
    tbl[19] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h3);
    tbl[20] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd3, 32'h0, 1, 32'h100, 32'h3);
    tbl[21] = mk(4'h0, 0, 32'h00, 0, 1, 0, 4'd0, 32'h0, 0, 32'h100, 32'h2);

    reset_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_inta", {31'b0, inta}, 32'h0);
    chk("rst_addr", inta_addr, 32'h100);
    @(negedge clk);
    reset_n = 1'b1;

    for (int r = 0; r < 22; r++) begin
      drive(tbl[r].irq, tbl[r].stall, tbl[r].pc, tbl[r].reti, tbl[r].rsr,
            tbl[r].wsr, tbl[r].addr, tbl[r].wd);
      #1;
      chk($sformatf("tbl%0d_inta", r), {31'b0, inta}, {31'b0, tbl[r].e_inta});
      chk($sformatf("tbl%0d_addr", r), inta_addr, tbl[r].e_addr);
      chk($sformatf("tbl%0d_sdo", r), sdo, tbl[r].e_sdo);
      cyc();
    end

    // Masking: request while IE=0 must wait until PCS enables it.
    drive(4'h0, 0, 0, 0, 0, 1, 4'd0, 32'h0); #1; cyc();
    drive(4'h1, 0, 0, 0, 0, 0, 4'd0, 32'h0); #1;
    chk("mask_pulse_inta", {31'b0, inta}, 32'h0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      idle(); #1;
      chk($sformatf("mask_hold%0d", k), {31'b0, inta}, 32'h0);
      cyc();
    end
    drive(4'h0, 0, 0, 0, 0, 1, 4'd0, 32'h1); #1; cyc();
    found = 0; at = -1;
    for (int k = 0; k < 4; k++) begin
      idle(); #1;
      if (!found && inta) begin found = 1; at = k; end
      cyc();
    end
    chk("mask_wake_seen", {31'b0, found}, 32'h1);
    chk("mask_wake_lat", {31'b0, (at < 2)}, 32'h1);

    // Stall holds off the take; ACK itself is not stretched by stall.
    drive(4'h0, 0, 0, 0, 0, 1, 4'd0, 32'h1); #1; cyc();
    drive(4'h2, 1, 0, 0, 0, 0, 4'd0, 32'h0); #1; cyc();
    for (int k = 0; k < 6; k++) begin
      drive(4'h0, 1, 0, 0, 0, 0, 4'd0, 32'h0); #1;
      chk($sformatf("stall_hold%0d", k), {31'b0, inta}, 32'h0);
      cyc();
    end
    drive(4'h0, 0, 32'h90, 0, 1, 0, 4'd3, 32'h0); #1;
    chk("stall_drop_inta", {31'b0, inta}, 32'h0);
    chk("stall_drop_idn", sdo, 32'h0);
    cyc();
    drive(4'h0, 1, 0, 0, 1, 0, 4'd3, 32'h0); #1;
    chk("stall_ack_inta", {31'b0, inta}, 32'h1);
    chk("stall_ack_addr", inta_addr, 32'h100);
    chk("stall_ack_idn", sdo, 32'h1);
    cyc();
    drive(4'h0, 1, 0, 0, 1, 0, 4'd2, 32'h0); #1;
    chk("stall_ack_width", {31'b0, inta}, 32'h0);
    chk("stall_ira", sdo, 32'h90);
    cyc();

    // Collision: WSR IHA while a request is pending and enabled.
    drive(4'h4, 0, 0, 0, 0, 0, 4'd0, 32'h0); #1; cyc();
    drive(4'h0, 0, 0, 0, 0, 1, 4'd0, 32'h1); #1;
    chk("coll_wsr_pcs_inta", {31'b0, inta}, 32'h0);
    cyc();
    drive(4'h0, 0, 0, 0, 0, 1, 4'd1, 32'h200); #1;
    chk("coll_wsr_iha_inta", {31'b0, inta}, 32'h0);
    cyc();
    drive(4'h0, 0, 0, 0, 1, 0, 4'd1, 32'h0); #1;
    chk("coll_take_inta", {31'b0, inta}, 32'h0);
    chk("coll_rar", sdo, 32'h200);
    cyc();
    idle(); #1;
    chk("coll_ack_inta", {31'b0, inta}, 32'h1);
    chk("coll_ack_addr", inta_addr, 32'h200);

    // Reset in the middle of the ACK cycle.
    reset_n = 1'b0; #1;
    chk("rst_mid_inta", {31'b0, inta}, 32'h0);
    chk("rst_mid_addr", inta_addr, 32'h100);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      drive(4'h0, 0, 0, 0, 1, 0, 4'(a), 32'h0); #1;
      chk($sformatf("rst2_rd%0d", a), sdo, (a == 1) ? 32'h100 : 32'h0);
      chk($sformatf("rst2_inta%0d", a), {31'b0, inta}, 32'h0);
      cyc();
    end

    // Randomized run against the reference model.
    idle();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    for (int n = 0; n < 400; n++) begin
      irq   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      stall = ($urandom_range(0, 3) == 0);
      pc_in = $urandom;
      sel   = $urandom_range(0, 9);
      is_reti = (sel == 0);
      is_wsr  = (sel == 1 || sel == 2);
      is_rsr  = $urandom_range(0, 1) == 1;
      sr_addr = 4'($urandom_range(0, 5));
      wdata   = $urandom;
      if (is_wsr && sr_addr == 4'd0 && $urandom_range(0, 2) != 0) wdata[0] = 1'b1;
      #1;
      chk($sformatf("rnd%0d_inta", n), {31'b0, inta}, {31'b0, m_ack});
      chk($sformatf("rnd%0d_addr", n), inta_addr,
          (!m_ack && is_reti) ? m_ira : m_iha);
      chk($sformatf("rnd%0d_sdo", n), sdo, is_rsr ? m_read(sr_addr) : 32'h0);
      @(posedge clk);
      m_edge();
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interrupt_unit.md
# interrupt_unit

System-register and interrupt-sequencing unit sitting beside the decode stage. Latches external interrupt requests and selects one by priority. Raises the one-cycle interrupt-acknowledge strobe that forces the decoder into its interrupt-vector fetch. Owns the PCS/IHA/IRA/IDN system registers that the decoder's RETI, RSR and WSR outputs read and write.

## Interface
- DATA_BIT_WIDTH, 32: width of system registers and addresses
- NUM_IRQ, 4: number of interrupt request lines (max 16)
- IHA_RESET, 32'h0000_0100: reset value of IHA (handler address)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- irq  in  NUM_IRQ  level-high device requests; bit 0 highest priority
- stall  in  1  pipeline hold (load-use or fetch stall); no interrupt is taken while high
- pcIn  in  DATA_BIT_WIDTH  PC of the instruction currently in decode (the return point)
- isReti, isRSR, isWSR  in  1  decoded system-instruction flags
- sysRegAddr  in  4  system register index (decoder s1RegAddr for RSR, dRegAddr for WSR)
- wrtData  in  DATA_BIT_WIDTH  GPR data for WSR
- sysDataOut  out  DATA_BIT_WIDTH  RSR read data
- intaSig  out  1  interrupt-acknowledge strobe to the decoder
- intaAddr  out  DATA_BIT_WIDTH  redirect target used when the decoder selects pcSel=2'b11

## Operation
- System registers:
  - Index 0 is PCS. Bit0 is IE, bit1 is OIE; other bits read 0.
  - Index 1 is IHA.
  - Index 2 is IRA.
  - Index 3 is IDN. It is zero-extended.
  - Other indices read 0 and ignore writes.
- Pending latch: pend[i] sets on any cycle irq[i]=1. It clears only on acknowledge of line i. It stays set after irq drops.
- Selection: sub-module picks the lowest set bit of pend. It yields a valid flag and an index.
- FSM has 2 states.
  - IDLE to ACK when valid & IE & !stall & !isReti & !isWSR & !intaSig.
  - ACK to IDLE unconditionally.
- Entering ACK (registered at the edge) does the following:
  - IRA<=pcIn
  - IDN<=index
  - OIE<=IE
  - IE<=0
  - pend[index]<=0
- intaSig = (state==ACK). intaAddr = IHA when intaSig, IRA when isReti (and !intaSig), else IHA.
- RETI (isReti & !intaSig): IE<=OIE at the edge. The decoder redirects to IRA the same cycle.
- RSR: sysDataOut = register[sysRegAddr], combinational. Otherwise sysDataOut=0.
- WSR (isWSR & !intaSig): register[sysRegAddr]<=wrtData at the edge. For PCS only bits[1:0] are written.
- Simultaneous events:
  - RETI or WSR in decode defers a pending interrupt by at least one cycle. The new IE is evaluated next cycle.
  - An irq arriving on an acknowledged line during ACK re-sets pend (set has priority over clear for other lines only).
  - For the same line, the clear wins in the ACK-entry cycle.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight ACK is abandoned.

## Timing
- Reset values: state=IDLE, pend=0, IE=0, OIE=0, IHA=IHA_RESET, IRA=0, IDN=0. Outputs: intaSig=0, intaAddr=IHA_RESET, sysDataOut=0.
- Latency: irq high at edge N sets pend at N. With IE=1 and no stall, intaSig is high for the cycle after edge N+1.
- intaSig is exactly one cycle wide. Back-to-back acknowledges are impossible because IE=0 after ACK.
- stall only gates entry to ACK. Once in ACK, intaSig is not extended by stall; the decoder consumes it the same cycle.
- RSR read-after-WSR to the same register in consecutive cycles returns the new value.

## Structure
- Shared package holds:
  - system register indices: SR_PCS=0, SR_IHA=1, SR_IRA=2, SR_IDN=3
  - PCS bit positions: PCS_IE=0, PCS_OIE=1
  - FSM state encoding: ST_IDLE, ST_ACK
  - pcSel encoding constant PCSEL_INTA=2'b11, shared with the decoder
- Sub-module: irq_prio_enc, parameterised by NUM_IRQ. It is a combinational lowest-index-first encoder producing valid and index.

## Test plan
- Reset then read all four: RSR idx0..3 returns 0, 0x100, 0, 0, with intaSig=0. Reset asserted during ACK drops intaSig asynchronously.
- Basic take:
  - Stimulus: WSR PCS=1, pulse irq[2] one cycle, pcIn=0x40.
  - Response: intaSig high one cycle, intaAddr=0x100. Afterwards IRA=0x40, IDN=2, PCS=2'b10, pend[2]=0.
- Priority: irq=4'b1010 with IE=1. The first ACK gives IDN=1, and irq[3] stays pending. RETI restores IE=1, then a second ACK gives IDN=3.
- RETI: with IRA=0x40 and OIE=1, isReti gives intaAddr=0x40 the same cycle and PCS=2'b11 the next.
- Masking and stall:
  - irq[0] with IE=0 gives no intaSig for 10 cycles; WSR PCS=1 is then followed by intaSig within 2 cycles.
  - With stall held, no intaSig until stall drops.
- Collision: interrupt pending the same cycle as WSR IHA=0x200. No ACK that cycle; the next-cycle ACK has intaAddr=0x200.
